// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - 10-bit level stream to 12-bit TLC5615-style SPI frames on a free-running frame timer.
// Optional build macro DAC_SPI_MIDSCALE_ON_IDLE_EN parks the DAC at midscale while data_en is low.
module dac_spi_driver #(
    parameter int FRAME_PERIOD = 200,
    parameter int SCLK_DIV     = 4
) (
    input  logic       clk_50MHz,
    input  logic       rstn,
    input  logic [9:0] data_in,
    input  logic       data_en,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);
    localparam int TW = $clog2(FRAME_PERIOD + 1);
    localparam int DW = $clog2(SCLK_DIV + 1);
    localparam logic [TW-1:0] TICK_VAL = TW'(FRAME_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

`ifdef DAC_SPI_MIDSCALE_ON_IDLE_EN
    localparam logic [11:0] IDLE_WORD = 12'h800;
`else
    localparam logic [11:0] IDLE_WORD = 12'h000;
`endif

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LO    = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [11:0]   word_q, word_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          din_q, din_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    logic          tick;
    logic          div_end;
    logic [11:0]   new_word;

    always_comb begin
        tick     = (tcnt_q == TICK_VAL);
        div_end  = (div_q == DIV_LAST);
        new_word = data_en ? {data_in, 2'b00} : IDLE_WORD;

        tcnt_d  = tick ? '0 : tcnt_q + TW'(1);
        state_d = state_q;
        div_d   = div_end ? '0 : div_q + DW'(1);
        bit_d   = bit_q;
        word_d  = word_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        din_d   = din_q;
        done_d  = 1'b0;
        // A tick that lands mid-frame is dropped; only IDLE may capture.
        ovr_d   = tick && busy_q;

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (tick) begin
                    state_d = S_SETUP;
                    word_d  = new_word;
                    cs_d    = 1'b0;
                    din_d   = new_word[11];
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    state_d = S_LO;
                    bit_d   = 4'd11;
                end
            end
            S_LO: begin
                if (div_end) begin
                    state_d = S_HI;
                    sclk_d  = 1'b1;
                end
            end
            S_HI: begin
                if (div_end) begin
                    sclk_d = 1'b0;
                    if (bit_q != 4'd0) begin
                        // Next bit goes out on the falling edge, a full half before its rise.
                        bit_d   = bit_q - 4'd1;
                        din_d   = word_q[bit_q - 4'd1];
                        state_d = S_LO;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (div_end) begin
                    state_d = S_IDLE;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50MHz or negedge rstn) begin
        if (!rstn) begin
            tcnt_q  <= '0;
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dac_cs_n   = cs_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;
endmodule
